// File: rtl/col_sense_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : col_sense_ctrl_pkg
//  Description : Shared types and constants for the column sense controller:
//                read-sequence state encoding, column width, default phase
//                lengths and phase counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package col_sense_ctrl_pkg;

    localparam int unsigned c_col_w       = 8;
    localparam int unsigned c_cnt_w       = 4;
    localparam int unsigned c_pre_cyc_def = 2;
    localparam int unsigned c_dev_cyc_def = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        DEV   = 3'd2,
        SENSE = 3'd3,
        LATCH = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/col_sense_ctrl_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : col_resolve
//  Description : Combinational per-column resolution of digitized BL/BLB
//                pairs into a data bit; equal levels mark the column as
//                unresolved, force its bit to 0 and raise the error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module col_resolve
    import col_sense_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = c_col_w
) (
    input  logic [WIDTH-1:0] i_bl,
    input  logic [WIDTH-1:0] i_blb,
    output logic [WIDTH-1:0] o_data,
    output logic             o_err
);

    logic [WIDTH-1:0] w_unres;

    for (genvar i = 0; i < WIDTH; i++) begin : g_col
        // A differential pair reads 1 only for BL high / BLB low.
        assign o_data[i]  = i_bl[i] & ~i_blb[i];
        assign w_unres[i] = ~(i_bl[i] ^ i_blb[i]);
    end

    assign o_err = |w_unres;

endmodule
`default_nettype wire

// File: rtl/col_sense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : col_sense_ctrl
//  Description : Column read sequencer: precharge, bitline development,
//                sense and latch phases with registered control outputs,
//                registered read data and an unresolved-column error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module col_sense_ctrl
    import col_sense_ctrl_pkg::*;
#(
    parameter int unsigned PRE_CYC = c_pre_cyc_def,
    parameter int unsigned DEV_CYC = c_dev_cyc_def
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs,
    input  logic               r_en,
    input  logic [c_col_w-1:0] BL,
    input  logic [c_col_w-1:0] BLB,
    output logic               pre_n,
    output logic               wl_en,
    output logic               sa_en,
    output logic [c_col_w-1:0] data_out,
    output logic               valid,
    output logic               err,
    output logic               busy
);

    localparam logic [c_cnt_w-1:0] c_pre_last = c_cnt_w'(PRE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_dev_last = c_cnt_w'(DEV_CYC - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_sample;
    logic [c_col_w-1:0]   w_col_data;
    logic                 w_col_err;

    col_resolve #(
        .WIDTH (c_col_w)
    ) u_col_resolve (
        .i_bl   (BL),
        .i_blb  (BLB),
        .o_data (w_col_data),
        .o_err  (w_col_err)
    );

    // State and phase counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; the counter restarts at zero on every phase change
    // and a dropped chip select aborts any active phase back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_sample    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cs && r_en) w_state_nxt = PRE;
            end
            PRE: begin
                if (!cs)                     w_state_nxt = IDLE;
                else if (r_cnt == c_pre_last) w_state_nxt = DEV;
                else                          w_cnt_nxt   = r_cnt + 1'b1;
            end
            DEV: begin
                if (!cs)                     w_state_nxt = IDLE;
                else if (r_cnt == c_dev_last) w_state_nxt = SENSE;
                else                          w_cnt_nxt   = r_cnt + 1'b1;
            end
            SENSE: begin
                if (!cs) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = LATCH;
                    w_sample    = 1'b1;
                end
            end
            LATCH:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe; wordline and precharge are
    // mutually exclusive by construction, abort included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_n    <= 1'b1;
            wl_en    <= 1'b0;
            sa_en    <= 1'b0;
            data_out <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            pre_n <= (w_state_nxt != PRE);
            wl_en <= (w_state_nxt == DEV) || (w_state_nxt == SENSE);
            sa_en <= (w_state_nxt == SENSE);
            valid <= w_sample;
            err   <= w_sample & w_col_err;
            busy  <= (w_state_nxt != IDLE);
            if (w_sample) data_out <= w_col_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_col_sense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_col_sense_ctrl
//  Description : Directed self-checking bench for col_sense_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_col_sense_ctrl;

    localparam int LAT = 6;  // accepting edge to valid, default phase lengths

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs;
    logic       r_en;
    logic [7:0] BL;
    logic [7:0] BLB;
    logic       pre_n;
    logic       wl_en;
    logic       sa_en;
    logic [7:0] data_out;
    logic       valid;
    logic       err;
    logic       busy;

    int n_checks = 0;
    int n_errs   = 0;
    logic mon_en = 1'b0;

    col_sense_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .r_en     (r_en),
        .BL       (BL),
        .BLB      (BLB),
        .pre_n    (pre_n),
        .wl_en    (wl_en),
        .sa_en    (sa_en),
        .data_out (data_out),
        .valid    (valid),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Continuous invariants: no wordline during precharge, no err without valid.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            assert (!(wl_en && !pre_n)) else begin
                n_errs++;
                $error("FAIL wl_pre_overlap: wl_en=%0b pre_n=%0b, required not both active", wl_en, pre_n);
            end
            n_checks++;
            assert (valid || !err) else begin
                n_errs++;
                $error("FAIL err_unqualified: err=%0b valid=%0b, required err=0 when valid=0", err, valid);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic e_pre_n, input logic e_wl,
                           input logic e_sa, input logic e_valid, input logic e_busy);
        chk({tag, "_pre_n"}, {7'd0, pre_n}, {7'd0, e_pre_n});
        chk({tag, "_wl_en"}, {7'd0, wl_en}, {7'd0, e_wl});
        chk({tag, "_sa_en"}, {7'd0, sa_en}, {7'd0, e_sa});
        chk({tag, "_valid"}, {7'd0, valid}, {7'd0, e_valid});
        chk({tag, "_busy"},  {7'd0, busy},  {7'd0, e_busy});
    endtask

    // k = edges since acceptance: 0..1 PRE, 2..4 DEV, 5 SENSE, 6 LATCH.
    task automatic chk_phase(input string tag, input int k);
        if (k < 2)       chk_ctl($sformatf("%s_k%0d", tag, k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        else if (k < 5)  chk_ctl($sformatf("%s_k%0d", tag, k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        else if (k == 5) chk_ctl($sformatf("%s_k%0d", tag, k), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        else             chk_ctl($sformatf("%s_k%0d", tag, k), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_read(input string tag, input logic [7:0] bl, input logic [7:0] blb,
                           input logic [7:0] exp_d, input logic exp_e);
        BL = bl; BLB = blb; cs = 1'b1; r_en = 1'b1;
        tick;
        r_en = 1'b0;
        for (int k = 0; k <= LAT; k++) begin
            if (k > 0) tick;
            chk_phase(tag, k);
        end
        chk({tag, "_data"}, data_out, exp_d);
        chk({tag, "_err"},  {7'd0, err}, {7'd0, exp_e});
        tick;
        chk_ctl({tag, "_idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_hold"},    data_out, exp_d);
        chk({tag, "_err_clr"}, {7'd0, err}, 8'd0);
    endtask

    initial begin
        int nv;
        int first_v;
        int second_v;

        // Reset
        rst_n = 1'b0; cs = 1'b0; r_en = 1'b0; BL = 8'h00; BLB = 8'h00;
        tick; tick;
        chk_ctl("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_data", data_out, 8'h00);
        chk("reset_err",  {7'd0, err}, 8'd0);
        mon_en = 1'b1;
        rst_n = 1'b1;
        tick;
        chk_ctl("idle0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clean read
        do_read("rd_a5", 8'hA5, 8'h5A, 8'hA5, 1'b0);

        // Bit0 resolves to 1; bits 1..7 have equal levels -> 0 with err
        do_read("rd_unres", 8'h0F, 8'h0E, 8'h01, 1'b1);

        // Fully unresolved, all-ones pair
        do_read("rd_all1", 8'hFF, 8'hFF, 8'h00, 1'b1);

        // r_en re-pulsed during DEV is ignored
        BL = 8'h3C; BLB = 8'hC3; cs = 1'b1; r_en = 1'b1;
        tick; r_en = 1'b0;
        tick; tick;
        chk("repulse_in_dev", {7'd0, wl_en}, 8'd1);
        r_en = 1'b1;
        tick; r_en = 1'b0;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (valid) nv++;
        end
        chk("repulse_nvalid", nv[7:0], 8'd1);
        chk("repulse_data", data_out, 8'h3C);

        // cs dropped in the 2nd DEV cycle
        BL = 8'hFF; BLB = 8'h00; cs = 1'b1; r_en = 1'b1;
        tick; r_en = 1'b0;
        tick; tick; tick;
        chk("abort_dev2", {7'd0, wl_en}, 8'd1);
        cs = 1'b0;
        tick;
        chk_ctl("abort_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_data", data_out, 8'h3C);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (valid) nv++;
        end
        chk("abort_nvalid", nv[7:0], 8'd0);
        chk("abort_data_late", data_out, 8'h3C);

        // Reset during SENSE
        BL = 8'h81; BLB = 8'h7E; cs = 1'b1; r_en = 1'b1;
        tick; r_en = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        chk("in_sense", {7'd0, sa_en}, 8'd1);
        rst_n = 1'b0;
        tick;
        chk_ctl("rst_sense", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_sense_data", data_out, 8'h00);
        chk("rst_sense_err",  {7'd0, err}, 8'd0);
        rst_n = 1'b1;
        tick;
        do_read("rd_post_rst", 8'h5A, 8'hA5, 8'h5A, 1'b0);

        // r_en held high for 20 cycles: accepts at 0, 8, 16 -> valid at 6, 14, 22
        BL = 8'hF0; BLB = 8'h0F; cs = 1'b1;
        nv = 0; first_v = -1; second_v = -1;
        for (int i = 0; i < 30; i++) begin
            r_en = (i < 20);
            tick;
            if (valid) begin
                if (nv == 0) first_v = i;
                else if (nv == 1) second_v = i;
                nv++;
            end
        end
        r_en = 1'b0;
        chk("b2b_nvalid", nv[7:0], 8'd3);
        chk("b2b_first",  first_v[7:0], 8'd6);
        chk("b2b_space",  8'(second_v - first_v), 8'd8);
        chk("b2b_data",   data_out, 8'hF0);

        tick;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
